// File: rtl/lcd_scanout_if.sv
// lcd_scanout_if: frame-buffer write port and mono video output bundle
interface lcd_scanout_if;
  logic [13:0] i_vram_a;
  logic [3:0]  i_vram_do;
  logic        i_vram_we;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_de;
  logic        o_pix;
  logic        o_img;
  logic        o_sof;
  modport master (output i_vram_a, i_vram_do, i_vram_we,
                  input  o_hsync, o_vsync, o_de, o_pix, o_img, o_sof);
  modport slave  (input  i_vram_a, i_vram_do, i_vram_we,
                  output o_hsync, o_vsync, o_de, o_pix, o_img, o_sof);
endinterface

// File: rtl/lcd_scanout.sv
// lcd_scanout: Z88 nibble frame buffer scanned out as a line-repeated mono video stream
module lcd_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int LINE_REP = 4,
  parameter int V_OFFSET = 112
) (
  input  logic          mck,
  input  logic          rin,
  input  logic          pix_ce,
  lcd_scanout_if.slave  bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int V_END   = V_OFFSET + 64 * LINE_REP;
  logic [3:0]    r_mem [0:16383];
  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [7:0]    r_rep;
  logic [5:0]    r_zrow;
  logic [13:0]   r_s1_addr;
  logic [1:0]    r_s1_sel, r_s2_sel;
  logic [3:0]    r_s2_nib;
  logic          r_s1_de, r_s1_img, r_s1_hs, r_s1_vs, r_s1_first;
  logic          r_s2_de, r_s2_img, r_s2_hs, r_s2_vs, r_s2_first;
  logic          r_hsync, r_vsync, r_de, r_pix, r_img, r_sof;
  logic          w_hwrap, w_last_rep, w_de, w_img, w_hs, w_vs, w_first;
  logic [VW-1:0] w_vnext;
  always_comb begin
    w_hwrap    = r_hcnt == HW'(H_TOTAL - 1);
    w_vnext    = (r_vcnt == VW'(V_TOTAL - 1)) ? '0 : r_vcnt + 1'b1;
    w_last_rep = r_rep == 8'(LINE_REP - 1);
    w_de       = r_hcnt < HW'(H_ACTIVE) && r_vcnt < VW'(V_ACTIVE);
    w_img      = r_vcnt >= VW'(V_OFFSET) && r_vcnt < VW'(V_END);
    w_hs       = !(r_hcnt >= HW'(H_ACTIVE + H_FP) && r_hcnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    w_vs       = !(r_vcnt >= VW'(V_ACTIVE + V_FP) && r_vcnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    w_first    = r_hcnt == '0 && r_vcnt == '0;
  end
  always_ff @(posedge mck)
    if (bus.i_vram_we && !rin) r_mem[bus.i_vram_a] <= bus.i_vram_do;
  always_ff @(posedge mck) begin
    if (rin) begin
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_rep      <= '0;
      r_zrow     <= '0;
      r_s1_addr  <= '0;
      r_s1_sel   <= '0;
      r_s1_de    <= 1'b0;
      r_s1_img   <= 1'b0;
      r_s1_hs    <= 1'b1;
      r_s1_vs    <= 1'b1;
      r_s1_first <= 1'b0;
      r_s2_nib   <= '0;
      r_s2_sel   <= '0;
      r_s2_de    <= 1'b0;
      r_s2_img   <= 1'b0;
      r_s2_hs    <= 1'b1;
      r_s2_vs    <= 1'b1;
      r_s2_first <= 1'b0;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_de       <= 1'b0;
      r_pix      <= 1'b0;
      r_img      <= 1'b0;
      r_sof      <= 1'b0;
    end else begin
      r_sof <= 1'b0;
      if (pix_ce) begin
        r_hcnt <= w_hwrap ? '0 : r_hcnt + 1'b1;
        if (w_hwrap) begin
          r_vcnt <= w_vnext;
          // zrow/rep step once per output line so no divide by LINE_REP is needed
          if (w_vnext == VW'(V_OFFSET)) begin
            r_rep  <= '0;
            r_zrow <= '0;
          end else if (w_img) begin
            r_rep  <= w_last_rep ? '0 : r_rep + 1'b1;
            r_zrow <= r_zrow + 6'(w_last_rep);
          end
        end
        r_s1_addr  <= {r_zrow, 8'(r_hcnt >> 2)};
        r_s1_sel   <= r_hcnt[1:0];
        r_s1_de    <= w_de;
        r_s1_img   <= w_img;
        r_s1_hs    <= w_hs;
        r_s1_vs    <= w_vs;
        r_s1_first <= w_first;
        r_s2_nib   <= r_mem[r_s1_addr];
        r_s2_sel   <= r_s1_sel;
        r_s2_de    <= r_s1_de;
        r_s2_img   <= r_s1_img;
        r_s2_hs    <= r_s1_hs;
        r_s2_vs    <= r_s1_vs;
        r_s2_first <= r_s1_first;
        r_pix      <= r_s2_nib[~r_s2_sel] & r_s2_de & r_s2_img;
        r_img      <= r_s2_img & r_s2_de;
        r_de       <= r_s2_de;
        r_hsync    <= r_s2_hs;
        r_vsync    <= r_s2_vs;
        r_sof      <= r_s2_first;
      end
    end
  end
  assign bus.o_hsync = r_hsync;
  assign bus.o_vsync = r_vsync;
  assign bus.o_de    = r_de;
  assign bus.o_pix   = r_pix;
  assign bus.o_img   = r_img;
  assign bus.o_sof   = r_sof;
endmodule

// File: tb/tb_lcd_scanout.sv
// tb_lcd_scanout: reduced-geometry scanout checked against a position-based reference model
module tb_lcd_scanout;
  localparam int HA = 16, HFP = 1, HSY = 2, HBP = 1;
  localparam int VA = 136, VFP = 2, VSY = 2, VBP = 3;
  localparam int LR = 2, VO = 4;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int F  = HT * VT;
  logic mck = 1'b0, rin = 1'b1, pix_ce = 1'b0;
  lcd_scanout_if bus();
  lcd_scanout #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
                .LINE_REP(LR), .V_OFFSET(VO))
    dut (.mck(mck), .rin(rin), .pix_ce(pix_ce), .bus(bus));
  always #5 mck = ~mck;
  int checks = 0, errors = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  // reference model: output after tick t shows screen position t-3, pixel fetched at tick t-1
  logic [3:0] m_mem [0:16383];
  int   m_t = 0;
  logic m_rd = 1'b0, e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_pix = 1'b0, e_img = 1'b0, e_sof = 1'b0;
  initial for (int i = 0; i < 16384; i++) m_mem[i] = 4'h0;
  function automatic logic pix_at(input int q);
    int h, v;
    h = q % HT;
    v = (q / HT) % VT;
    if (h >= HA || v >= VA || v < VO || v >= VO + 64 * LR) return 1'b0;
    return m_mem[((v - VO) / LR) * 256 + h / 4][3 - h % 4];
  endfunction
  always @(posedge mck) begin
    int p, h, v;
    if (rin) begin
      m_t = 0; m_rd = 0; e_hs = 1; e_vs = 1; e_de = 0; e_pix = 0; e_img = 0; e_sof = 0;
    end else begin
      e_sof = 0;
      if (pix_ce) begin
        m_t++;
        if (m_t >= 3) begin
          p = m_t - 3;
          h = p % HT;
          v = (p / HT) % VT;
          e_de  = h < HA && v < VA;
          e_hs  = !(h >= HA + HFP && h < HA + HFP + HSY);
          e_vs  = !(v >= VA + VFP && v < VA + VFP + VSY);
          e_img = e_de && v >= VO && v < VO + 64 * LR;
          e_pix = m_rd;
          e_sof = (p % F) == 0;
        end
        if (m_t >= 2) m_rd = pix_at(m_t - 2);
      end
      if (bus.i_vram_we) m_mem[bus.i_vram_a] = bus.i_vram_do;
    end
  end
  bit chk_on = 0;
  always @(negedge mck) if (chk_on) begin
    chk("hsync", bus.o_hsync, e_hs);
    chk("vsync", bus.o_vsync, e_vs);
    chk("de", bus.o_de, e_de);
    chk("pix", bus.o_pix, e_pix);
    chk("img", bus.o_img, e_img);
    chk("sof", bus.o_sof, e_sof);
  end
  // frame capture keyed on o_sof, independent of the model
  bit ce_q = 0, rin_q = 1, cap_ok = 0;
  int pos = 0, frames = 0;
  logic [HA-1:0] cap [VA];
  logic [HA-1:0] snap [VA];
  logic [VA-1:0] img_l = '0, snap_img = '0;
  always @(posedge mck) begin
    ce_q  = pix_ce;
    rin_q = rin;
  end
  always @(negedge mck) begin
    if (rin_q) cap_ok = 0;
    else if (ce_q) begin
      if (bus.o_sof) begin
        snap = cap; snap_img = img_l; img_l = '0; frames++; pos = 0; cap_ok = 1;
      end else pos++;
      if (cap_ok && pos % HT < HA && pos / HT < VA) begin
        cap[pos / HT][pos % HT] = bus.o_pix;
        if (bus.o_img) img_l[pos / HT] = 1'b1;
      end
    end
  end
  task automatic wr(input logic [13:0] a, input logic [3:0] d);
    bus.i_vram_a = a; bus.i_vram_do = d; bus.i_vram_we = 1'b1;
    @(negedge mck);
    bus.i_vram_we = 1'b0;
  endtask
  task automatic wait_frame();
    int f0 = frames;
    int n = 0;
    while (frames == f0 && n < 4 * F + 100) begin @(negedge mck); n++; end
    if (frames == f0) chk("frame_timeout", 0, 1);
    @(negedge mck);
  endtask
  task automatic wait_tick(input int target, input int modulo);
    int n = 0;
    while ((m_t % modulo) != target && n < 2 * F + 100) begin @(negedge mck); n++; end
    if ((m_t % modulo) != target) chk("tick_timeout", m_t, target);
  endtask
  initial begin
    int n, w;
    bus.i_vram_we = 0; bus.i_vram_a = '0; bus.i_vram_do = '0;
    rin = 1; pix_ce = 1;
    repeat (3) @(negedge mck);
    chk_on = 1;
    chk("rst_hsync", bus.o_hsync, 1);
    chk("rst_vsync", bus.o_vsync, 1);
    chk("rst_de", bus.o_de, 0);
    chk("rst_pix", bus.o_pix, 0);
    chk("rst_img", bus.o_img, 0);
    chk("rst_sof", bus.o_sof, 0);
    pix_ce = 0; rin = 0;
    for (int z = 0; z < 64; z++)
      for (int k = 0; k < HA / 4; k++) wr({z[5:0], 8'(k)}, 4'h0);
    wr(14'h0000, 4'b1000);
    wr(14'h0003, 4'b0001);
    wr(14'h3F00, 4'hF);
    pix_ce = 1;
    n = 0;
    do begin @(negedge mck); n++; end while (bus.o_hsync && n < 200);
    chk("hs_first_tick", n, 3 + HA + HFP);
    w = 0;
    while (!bus.o_hsync && w < 200) begin @(negedge mck); w++; end
    chk("hs_width", w, HSY);
    n = 0;
    while (bus.o_vsync && n < 2 * F) begin @(negedge mck); n++; end
    n = 0;
    while (!bus.o_vsync && n < 2 * F) begin @(negedge mck); n++; end
    while (bus.o_vsync && n < 2 * F) begin @(negedge mck); n++; end
    chk("vs_period", n, 2860);
    wait_frame();
    chk("l3_blank", int'(snap[3]), 0);
    chk("l4_edges", int'(snap[4]), 32'h8001);
    chk("l5_edges", int'(snap[5]), 32'h8001);
    chk("l6_blank", int'(snap[6]), 0);
    chk("l130_left", int'(snap[130]), 32'h000F);
    chk("l131_left", int'(snap[131]), 32'h000F);
    chk("l132_blank", int'(snap[132]), 0);
    chk("img_count", $countones(snap_img), 128);
    chk("img_l3", int'(snap_img[3]), 0);
    chk("img_l4", int'(snap_img[4]), 1);
    chk("img_l131", int'(snap_img[131]), 1);
    chk("img_l132", int'(snap_img[132]), 0);
    wait_tick(81, F);
    bus.i_vram_a = 14'h0000; bus.i_vram_do = 4'b0001; bus.i_vram_we = 1'b1;
    @(negedge mck);
    bus.i_vram_we = 1'b0;
    wait_frame();
    chk("rbw_l4_old", int'(snap[4]), 32'h8009);
    chk("rbw_l5_new", int'(snap[5]), 32'h8008);
    wait_frame();
    chk("rbw_l4_next", int'(snap[4]), 32'h8008);
    wait_tick(70 * HT + 5, F);
    rin = 1;
    @(negedge mck);
    chk("mid_rst_hsync", bus.o_hsync, 1);
    chk("mid_rst_de", bus.o_de, 0);
    chk("mid_rst_pix", bus.o_pix, 0);
    rin = 0;
    wait_frame();
    wait_frame();
    chk("keep_l4", int'(snap[4]), 32'h8008);
    chk("keep_l130", int'(snap[130]), 32'h000F);
    for (int c = 0; c < 4 * F + 400; c++) begin
      pix_ce = (c % 4) == 0;
      bus.i_vram_we = $urandom_range(0, 3) == 0;
      bus.i_vram_a  = $urandom_range(0, 1) ? {6'($urandom), 8'($urandom_range(0, 3))} : 14'($urandom);
      bus.i_vram_do = 4'($urandom);
      @(negedge mck);
    end
    bus.i_vram_we = 0; pix_ce = 1;
    repeat (20) @(negedge mck);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
